// File: rtl/int_sequencer.sv
// Interrupt/reset sequencer for the 6502 core: synchronizes NMI/IRQ, arbitrates
// against software BRK, injects a forced BRK at instruction boundaries and steers
// the vector address, B flag, write suppression and I-flag set during T2_BRK.
module int_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = 16'hFFFA,
  parameter logic [15:0] VEC_RST     = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ     = 16'hFFFE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        sync,
  input  logic        brk_op,
  input  logic        vec_rd,
  input  logic        vec_done,
  output logic        force_brk,
  output logic        suppress_wr,
  output logic        b_flag,
  output logic        set_i,
  output logic [15:0] vec_addr,
  output logic [1:0]  src,
  output logic        busy
);

  localparam logic [1:0] SRC_RST = 2'd0;
  localparam logic [1:0] SRC_NMI = 2'd1;
  localparam logic [1:0] SRC_IRQ = 2'd2;
  localparam logic [1:0] SRC_BRK = 2'd3;

  typedef enum logic [1:0] {S_RST, S_RUN, S_SEQ} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] nmi_sr, irq_sr;
  logic                   nmi_s, irq_s, nmi_s_d;
  logic                   nmi_fall, irq_act;
  logic                   nmi_pend, first, vec_seen;
  logic [1:0]             src_q, src_n;
  logic                   b_q, b_n;

  assign nmi_s    = nmi_sr[SYNC_STAGES-1];
  assign irq_s    = irq_sr[SYNC_STAGES-1];
  assign nmi_fall = nmi_s_d & ~nmi_s;
  // IRQ is a level request gated by the live I bit, so a CLI takes effect at once.
  assign irq_act  = ~irq_s & ~i_flag;
  assign src      = src_q;

  function automatic logic [15:0] vec_sel(input logic [1:0] s);
    case (s)
      SRC_NMI:          vec_sel = VEC_NMI;
      SRC_IRQ, SRC_BRK: vec_sel = VEC_IRQ;
      default:          vec_sel = VEC_RST;
    endcase
  endfunction

  // Synchronizer chains; idle-high so reset never fabricates an NMI edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      nmi_sr  <= '1;
      irq_sr  <= '1;
      nmi_s_d <= 1'b1;
    end else begin
      nmi_sr  <= {nmi_sr[SYNC_STAGES-2:0], nmi_n};
      irq_sr  <= {irq_sr[SYNC_STAGES-2:0], irq_n};
      nmi_s_d <= nmi_s;
    end
  end

  // NMI pending latch: new edge beats the completion clear of the current NMI.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      nmi_pend <= 1'b0;
    else if (nmi_fall)
      nmi_pend <= 1'b1;
    else if (state == S_SEQ && vec_done && src_q == SRC_NMI)
      nmi_pend <= 1'b0;
  end

  // State, latched source/B flag, reset first-cycle flag and vector-read tracker.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_RST;
      src_q    <= SRC_RST;
      b_q      <= 1'b0;
      first    <= 1'b1;
      vec_seen <= 1'b0;
    end else begin
      state    <= state_n;
      src_q    <= src_n;
      b_q      <= b_n;
      first    <= 1'b0;
      vec_seen <= (state == S_SEQ) & (vec_seen | vec_rd);
    end
  end

  // Next state, source arbitration/hijack and sequence outputs.
  always_comb begin
    state_n     = state;
    src_n       = src_q;
    b_n         = b_q;
    force_brk   = 1'b0;
    suppress_wr = 1'b0;
    b_flag      = 1'b0;
    set_i       = 1'b0;
    busy        = 1'b0;
    vec_addr    = vec_sel(src_q);
    case (state)
      S_RST: begin
        force_brk   = first;
        suppress_wr = 1'b1;
        busy        = 1'b1;
        set_i       = vec_rd;
        vec_addr    = VEC_RST;
        if (vec_done) state_n = S_RUN;
      end
      S_RUN: begin
        if (sync && (nmi_pend || irq_act)) begin
          force_brk = 1'b1;
          src_n     = nmi_pend ? SRC_NMI : SRC_IRQ;
          b_n       = 1'b0;
          state_n   = S_SEQ;
        end else if (brk_op) begin
          src_n   = SRC_BRK;
          b_n     = 1'b1;
          state_n = S_SEQ;
        end
      end
      S_SEQ: begin
        busy   = 1'b1;
        b_flag = b_q;
        set_i  = vec_rd;
        // Late NMI steals the vector until the first vector read; B keeps the pushed value.
        if (nmi_pend && src_q[1] && !vec_seen && !vec_rd) src_n = SRC_NMI;
        if (vec_done) state_n = S_RUN;
      end
      default: state_n = S_RST;
    endcase
    if (i_rst) begin
      force_brk   = 1'b0;
      suppress_wr = 1'b1;
      b_flag      = 1'b0;
      set_i       = 1'b0;
      vec_addr    = VEC_RST;
      busy        = 1'b1;
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: directed table, hand sequences for multi-cycle corners,
// and random stimulus against a cycle-level reference model of the sequencer rules.
module tb_int_sequencer;
  localparam int SS = 2;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst, nmi_n, irq_n, i_flag, sync, brk_op, vec_rd, vec_done;
  logic        force_brk, suppress_wr, b_flag, set_i, busy;
  logic [15:0] vec_addr;
  logic [1:0]  src;

  int_sequencer #(.SYNC_STAGES(SS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
    .sync(sync), .brk_op(brk_op), .vec_rd(vec_rd), .vec_done(vec_done),
    .force_brk(force_brk), .suppress_wr(suppress_wr), .b_flag(b_flag), .set_i(set_i),
    .vec_addr(vec_addr), .src(src), .busy(busy)
  );

  typedef struct packed {
    logic rst, nmi_n, irq_n, i_flag, sync, brk_op, vec_rd, vec_done;
  } in_t;
  typedef struct packed {
    logic force_brk, suppress_wr, b_flag, set_i;
    logic [15:0] vec_addr;
    logic [1:0]  src;
    logic        busy;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  in_t  cur;
  out_t o;

  // Reference model: phase 0 = reset sequence, 1 = running, 2 = interrupt sequence.
  int m_phase, m_src;
  bit m_b, m_pend, m_first, m_seen;
  bit nh[0:SS];  // nh[k] = nmi_n as sampled k+1 edges ago
  bit ih[0:SS];

  function automatic logic [15:0] vec_of(int s);
    if (s == 1) return 16'hFFFA;
    if (s >= 2) return 16'hFFFE;
    return 16'hFFFC;
  endfunction

  function automatic out_t m_out(in_t i);
    out_t r;
    bit   irq_act;
    irq_act = !ih[SS-1] && !i.i_flag;
    r = '0;
    r.src = 2'(m_src);
    if (i.rst) begin
      r.suppress_wr = 1'b1; r.vec_addr = 16'hFFFC; r.busy = 1'b1;
    end else if (m_phase == 0) begin
      r.force_brk = m_first; r.suppress_wr = 1'b1; r.set_i = i.vec_rd;
      r.vec_addr = 16'hFFFC; r.busy = 1'b1;
    end else if (m_phase == 1) begin
      r.force_brk = i.sync && (m_pend || irq_act);
      r.vec_addr  = vec_of(m_src);
    end else begin
      r.b_flag = m_b; r.set_i = i.vec_rd; r.vec_addr = vec_of(m_src); r.busy = 1'b1;
    end
    return r;
  endfunction

  task automatic m_step(in_t i);
    bit fall, irq_act, npend, nb, nseen;
    int nph, nsrc;
    fall    = nh[SS] && !nh[SS-1];
    irq_act = !ih[SS-1] && !i.i_flag;
    if (i.rst) begin
      m_phase = 0; m_src = 0; m_pend = 0; m_first = 1; m_b = 0; m_seen = 0;
      for (int k = 0; k <= SS; k++) begin nh[k] = 1; ih[k] = 1; end
    end else begin
      nph = m_phase; nsrc = m_src; npend = m_pend; nb = m_b;
      if (fall) npend = 1;
      else if (m_phase == 2 && i.vec_done && m_src == 1) npend = 0;
      if (m_phase == 0) begin
        if (i.vec_done) nph = 1;
      end else if (m_phase == 1) begin
        if (i.sync && (m_pend || irq_act)) begin
          nph = 2; nsrc = m_pend ? 1 : 2; nb = 0;
        end else if (i.brk_op) begin
          nph = 2; nsrc = 3; nb = 1;
        end
      end else begin
        if (m_pend && m_src >= 2 && !m_seen && !i.vec_rd) nsrc = 1;
        if (i.vec_done) nph = 1;
      end
      nseen = (m_phase == 2) && (m_seen || i.vec_rd);
      for (int k = SS; k > 0; k--) begin nh[k] = nh[k-1]; ih[k] = ih[k-1]; end
      nh[0] = i.nmi_n; ih[0] = i.irq_n;
      m_phase = nph; m_src = nsrc; m_pend = npend; m_b = nb; m_seen = nseen; m_first = 0;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", nm, ncyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic tick();
    out_t e;
    @(negedge i_clk);
    {i_rst, nmi_n, irq_n, i_flag, sync, brk_op, vec_rd, vec_done} = cur;
    #1;
    e = m_out(cur);
    o = '{force_brk, suppress_wr, b_flag, set_i, vec_addr, src, busy};
    chk("model", 32'(o), 32'(e));
    m_step(cur);
    ncyc++;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_rd_done();
    cur.vec_rd = 1; tick(); cur.vec_rd = 0;
    cur.vec_done = 1; tick(); cur.vec_done = 0;
  endtask

  function automatic in_t mi(bit r, bit n, bit q, bit f, bit s, bit b, bit rd, bit d);
    return '{r, n, q, f, s, b, rd, d};
  endfunction
  function automatic out_t mo(bit fb, bit sw, bit bf, bit si, logic [15:0] a, logic [1:0] s, bit bz);
    return '{fb, sw, bf, si, a, s, bz};
  endfunction

  vec_t tbl[12];
  int   nfb;

  initial begin
    cur = mi(1, 1, 1, 1, 0, 0, 0, 0);
    {i_rst, nmi_n, irq_n, i_flag, sync, brk_op, vec_rd, vec_done} = cur;
    @(posedge i_clk); @(posedge i_clk);
    m_step(cur);

    // Reset release and a software BRK sequence.
    tbl[0]  = '{mi(1,1,1,1,0,0,0,0), mo(0,1,0,0,16'hFFFC,0,1)};
    tbl[1]  = '{mi(0,1,1,1,0,0,0,0), mo(1,1,0,0,16'hFFFC,0,1)};
    tbl[2]  = '{mi(0,1,1,1,0,0,0,0), mo(0,1,0,0,16'hFFFC,0,1)};
    tbl[3]  = '{mi(0,1,1,1,0,0,1,0), mo(0,1,0,1,16'hFFFC,0,1)};
    tbl[4]  = '{mi(0,1,1,1,0,0,0,1), mo(0,1,0,0,16'hFFFC,0,1)};
    tbl[5]  = '{mi(0,1,1,1,0,0,0,0), mo(0,0,0,0,16'hFFFC,0,0)};
    tbl[6]  = '{mi(0,1,1,1,1,0,0,0), mo(0,0,0,0,16'hFFFC,0,0)};
    tbl[7]  = '{mi(0,1,1,1,0,1,0,0), mo(0,0,0,0,16'hFFFC,0,0)};
    tbl[8]  = '{mi(0,1,1,1,0,0,0,0), mo(0,0,1,0,16'hFFFE,3,1)};
    tbl[9]  = '{mi(0,1,1,1,0,0,1,0), mo(0,0,1,1,16'hFFFE,3,1)};
    tbl[10] = '{mi(0,1,1,1,0,0,0,1), mo(0,0,1,0,16'hFFFE,3,1)};
    tbl[11] = '{mi(0,1,1,1,0,0,0,0), mo(0,0,0,0,16'hFFFE,3,0)};
    for (int k = 0; k < 12; k++) begin
      cur = tbl[k].i;
      tick();
      chk($sformatf("tbl%0d", k), 32'(o), 32'(tbl[k].o));
    end

    // IRQ masked for 10 syncs, then unmasked.
    cur.irq_n = 0; cur.i_flag = 1; nfb = 0;
    for (int k = 0; k < 10; k++) begin
      cur.sync = 1; tick(); nfb += int'(o.force_brk);
      cur.sync = 0; tick(); nfb += int'(o.force_brk);
    end
    chk("irq_masked_fb", 32'(nfb), 32'd0);
    cur.i_flag = 0; cur.sync = 1; tick(); chk("irq_fb", 32'(o.force_brk), 32'd1);
    cur.sync = 0; tick();
    chk("irq_src", 32'(o.src), 32'd2);
    chk("irq_vec", 32'(o.vec_addr), 32'hFFFE);
    chk("irq_b", 32'(o.b_flag), 32'd0);
    cur.vec_rd = 1; tick(); chk("irq_seti", 32'(o.set_i), 32'd1); cur.vec_rd = 0;
    cur.vec_done = 1; tick(); cur.vec_done = 0;
    cur.i_flag = 1;

    // NMI edge and IRQ at the same sync: NMI first, IRQ on the next sync.
    cur.nmi_n = 0; ticks(4);
    cur.i_flag = 0; cur.sync = 1; tick(); chk("both_fb", 32'(o.force_brk), 32'd1);
    cur.sync = 0; tick();
    chk("both_src", 32'(o.src), 32'd1);
    chk("both_vec", 32'(o.vec_addr), 32'hFFFA);
    pulse_rd_done();
    cur.sync = 1; tick(); chk("both_irq_fb", 32'(o.force_brk), 32'd1);
    cur.sync = 0; tick(); chk("both_irq_src", 32'(o.src), 32'd2);
    pulse_rd_done();
    cur.irq_n = 1; cur.i_flag = 1;

    // NMI held low: exactly one sequence; re-assert gives another.
    nfb = 0;
    for (int k = 0; k < 50; k++) begin
      cur.sync = k[0]; tick(); nfb += int'(o.force_brk);
    end
    cur.sync = 0;
    chk("nmi_held", 32'(nfb), 32'd0);
    cur.nmi_n = 1; ticks(4);
    cur.nmi_n = 0; ticks(3);
    cur.sync = 1; tick(); chk("nmi_again_fb", 32'(o.force_brk), 32'd1);
    cur.sync = 0; tick(); chk("nmi_again_src", 32'(o.src), 32'd1);
    pulse_rd_done();

    // BRK hijacked by an NMI edge before the vector read.
    cur.nmi_n = 1; ticks(4);
    cur.brk_op = 1; tick(); cur.brk_op = 0;
    ticks(2);
    cur.nmi_n = 0; ticks(5);
    chk("hijack_src", 32'(o.src), 32'd1);
    chk("hijack_vec", 32'(o.vec_addr), 32'hFFFA);
    chk("hijack_b", 32'(o.b_flag), 32'd1);
    pulse_rd_done();

    // NMI edge after the first vector read: BRK completes, NMI follows at next sync.
    cur.nmi_n = 1; ticks(4);
    cur.brk_op = 1; tick(); cur.brk_op = 0;
    cur.vec_rd = 1; tick(); cur.vec_rd = 0;
    cur.nmi_n = 0; ticks(5);
    chk("late_src", 32'(o.src), 32'd3);
    chk("late_b", 32'(o.b_flag), 32'd1);
    cur.vec_done = 1; tick(); cur.vec_done = 0;
    cur.sync = 1; tick(); chk("late_fb", 32'(o.force_brk), 32'd1);
    cur.sync = 0; tick(); chk("late_nmi_src", 32'(o.src), 32'd1);
    pulse_rd_done();

    // Reset in the middle of an NMI sequence with NMI still pending.
    cur.nmi_n = 1; ticks(4);
    cur.nmi_n = 0; ticks(3);
    cur.sync = 1; tick(); cur.sync = 0;
    tick(); chk("mid_src", 32'(o.src), 32'd1);
    cur.rst = 1; cur.nmi_n = 1; ticks(2);
    cur.rst = 0; tick();
    chk("mid_rel_src", 32'(o.src), 32'd0);
    chk("mid_rel_vec", 32'(o.vec_addr), 32'hFFFC);
    chk("mid_rel_fb", 32'(o.force_brk), 32'd1);
    cur.vec_done = 1; tick(); cur.vec_done = 0;
    nfb = 0;
    for (int k = 0; k < 8; k++) begin
      cur.sync = 1; tick(); nfb += int'(o.force_brk);
    end
    cur.sync = 0;
    chk("mid_no_nmi", 32'(nfb), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cur.rst      = ($urandom_range(199) == 0);
      if ($urandom_range(19) == 0) cur.nmi_n  = ~cur.nmi_n;
      if ($urandom_range(14) == 0) cur.irq_n  = ~cur.irq_n;
      if ($urandom_range(9)  == 0) cur.i_flag = ~cur.i_flag;
      cur.sync     = ($urandom_range(3) == 0);
      cur.brk_op   = ($urandom_range(15) == 0);
      cur.vec_rd   = ($urandom_range(5) == 0);
      cur.vec_done = ($urandom_range(7) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Interrupt and reset sequencer for the 6502 core.
- Samples NMI, IRQ and RESET events and arbitrates them against software BRK.
- At an instruction boundary it injects a forced BRK (opcode 0x00) into the instruction register, so decode enters its T2_BRK sequence.
- Through that sequence it supplies the vector address, the B-flag value, write suppression and I-flag set control.

Parameters:
- SYNC_STAGES, 2: synchronizer flops on nmi_n and irq_n (minimum 2).
- VEC_NMI, 16'hFFFA: NMI vector low-byte address.
- VEC_RST, 16'hFFFC: reset vector low-byte address.
- VEC_IRQ, 16'hFFFE: IRQ/BRK vector low-byte address.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- nmi_n  in  1  async NMI request, active-low, edge-triggered.
- irq_n  in  1  async IRQ request, active-low, level.
- i_flag  in  1  processor status I bit (P[2]).
- sync  in  1  opcode-fetch cycle (T0_FETCH), i.e. instruction boundary.
- brk_op  in  1  pulse: decode entered T2_BRK for a fetched (software) BRK.
- vec_rd  in  1  core is reading the vector low byte this cycle.
- vec_done  in  1  pulse: PC loaded from vector; sequence complete.
- force_brk  out  1  load 0x00 into IR instead of the fetched byte.
- suppress_wr  out  1  convert stack pushes to reads (reset only).
- b_flag  out  1  value for bit 4 of pushed P.
- set_i  out  1  set P[I] this cycle.
- vec_addr  out  16  vector low-byte address; the core fetches high at +1.
- src  out  2  active source: 0 RST, 1 NMI, 2 IRQ, 3 BRK.
- busy  out  1  sequence in progress.

Behaviour:

Synchronizers and pending state:
- nmi_n and irq_n pass through SYNC_STAGES flops, reset to 1. The bench counts latency from these flop outputs (nmi_s, irq_s).
- nmi_pend sets on a 1->0 transition of nmi_s and clears on vec_done when src==NMI.
- If the set and clear occur in the same cycle, set wins.
- Holding nmi_n low yields exactly one NMI.
- irq_act = !irq_s & !i_flag. It is combinational, not latched.

FSM states:
- S_RST
- S_RUN
- S_SEQ

While i_rst=1:
- state goes to S_RST.
- nmi_pend=0, src=0.
- Outputs: force_brk=0, suppress_wr=1, b_flag=0, set_i=0, vec_addr=VEC_RST, busy=1.

S_RST:
- force_brk=1 on the first cycle after i_rst deasserts, via a one-cycle first flag. It is 0 afterwards.
- suppress_wr=1 throughout.
- vec_addr=VEC_RST.
- set_i=vec_rd.
- On vec_done, go to S_RUN.
- An NMI edge during S_RST latches into nmi_pend and is serviced at the first sync in S_RUN.

S_RUN (busy=0):
- At a cycle with sync=1, priority is nmi_pend > irq_act.
- If either is active: force_brk=1 combinationally in that same cycle, src is latched (1 or 2), and the state goes to S_SEQ.
- If brk_op=1 and no forced BRK was injected: src=3 and the state goes to S_SEQ.
- force_brk is never asserted outside a sync cycle in S_RUN.

S_SEQ (busy=1):
- vec_addr is selected from src: 1 -> VEC_NMI; 2 or 3 -> VEC_IRQ.
- b_flag = (src==3).
- set_i = vec_rd.
- NMI hijack: if nmi_pend=1 and src is 2 or 3, src switches to 1 in any cycle before the first vec_rd cycle of this sequence.
  - b_flag keeps its value from before the switch. Pushes already occurred, so a BRK hijack still pushes B=1.
  - src is frozen from the first vec_rd cycle onward.
- On vec_done, go to S_RUN.

Timing and boundary conditions:
- i_rst at any time aborts the sequence: the state returns to S_RST and nmi_pend clears.
- vec_done outside S_RST/S_SEQ is ignored.
- IRQ deasserting after the sync decision does not cancel the sequence.
- Latency is one cycle from the first asserted nmi_s to nmi_pend.
- A sync cycle in which i_flag is cleared by the preceding instruction (CLI) uses the i_flag value present on the input that cycle.

Test Plan:
- Reset release: i_rst 1->0 -> force_brk=1 for exactly 1 cycle, suppress_wr=1 and vec_addr=16'hFFFC until vec_done, then busy=0 and suppress_wr=0.
- IRQ masked/unmasked:
  - irq_n=0 with i_flag=1 for 10 syncs -> force_brk never 1.
  - Then i_flag=0 -> next sync gives force_brk=1, src=2, vec_addr=16'hFFFE, b_flag=0, set_i=1 on vec_rd.
- Simultaneous NMI edge and IRQ at the same sync -> src=1, vec_addr=16'hFFFA. After vec_done, with irq still low and i_flag=0, the next sync gives src=2.
- NMI held low for 50 cycles -> one sequence only. Releasing and re-asserting nmi_n -> second sequence.
- BRK hijack:
  - brk_op pulse, then NMI edge two cycles later, before vec_rd -> src=1, vec_addr=16'hFFFA, b_flag=1.
  - An edge after the first vec_rd -> src stays 3, and the NMI is serviced at the next sync.
- Reset mid-sequence: i_rst during S_SEQ with src=1 and nmi_pend set -> after release, src=0, nmi_pend=0, vec_addr=16'hFFFC, and no NMI sequence follows.
